// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES job arbiter.
// The watchdog is compiled in only when AES_ARB_TIMEOUT_EN is defined.
package aes_arb_pkg;

    localparam int unsigned AES_BLK_W              = 128;
    localparam int unsigned AES_KSEL_W             = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StSettle,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module aes_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IdxW-1:0]    off;
    logic [IdxW:0]      sum;

    always_comb begin
        // Rotate so that bit 0 corresponds to the requester at ptr.
        rot = NUM_REQ'({req, req} >> ptr);
        any = 1'b0;
        off = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = IdxW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IdxW + 1)'(NUM_REQ)) begin
            sum = sum - (IdxW + 1)'(NUM_REQ);
        end
        idx = sum[IdxW-1:0];
        gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j] = any && (idx == IdxW'(j));
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES-192 core among NUM_REQ requesters, one job in flight at a time.
// Define AES_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog.
module aes_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              acct_en_i,
    input  logic                            debug_mode_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*AES_BLK_W-1:0]    req_pc_i,
    input  logic [NUM_REQ*AES_BLK_W-1:0]    req_state_i,
    input  logic [NUM_REQ*AES_KSEL_W-1:0]   req_key_sel_i,
    output logic [NUM_REQ-1:0]              resp_valid_o,
    input  logic [NUM_REQ-1:0]              resp_ready_i,
    output logic [AES_BLK_W-1:0]            resp_ct_o,
    output logic                            resp_err_o,
    output logic                            aes_start_o,
    output logic [AES_BLK_W-1:0]            aes_pc_o,
    output logic [AES_BLK_W-1:0]            aes_state_o,
    output logic [AES_KSEL_W-1:0]           aes_key_sel_o,
    input  logic [AES_BLK_W-1:0]            aes_ct_i,
    input  logic                            aes_ct_valid_i,
    output logic                            busy_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("aes_job_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [AES_BLK_W-1:0]  pc_q, pc_d;
    logic [AES_BLK_W-1:0]  st_q, st_d;
    logic [AES_BLK_W-1:0]  ct_q, ct_d;
    logic [AES_KSEL_W-1:0] ksel_q, ksel_d;
`ifdef AES_ARB_TIMEOUT_EN
    logic [31:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_any;

    assign eligible = debug_mode_i ? '0 : (req_valid_i & acct_en_i);

    aes_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req(eligible),
        .ptr(ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            owner_oh[j] = (grant_q == IdxW'(j));
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        pc_d         = pc_q;
        st_d         = st_q;
        ksel_d       = ksel_q;
        ct_d         = ct_q;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        req_ready_o  = '0;
        resp_valid_o = '0;
        aes_start_o  = 1'b0;

        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    req_ready_o = arb_gnt;
                    grant_d     = arb_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            pc_d   = req_pc_i[i*AES_BLK_W +: AES_BLK_W];
                            st_d   = req_state_i[i*AES_BLK_W +: AES_BLK_W];
                            ksel_d = req_key_sel_i[i*AES_KSEL_W +: AES_KSEL_W];
                        end
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                aes_start_o = 1'b1;
                state_d     = StSettle;
            end
            StSettle: begin
                // Core valid is ignored here so a stale valid from the last job is dropped.
`ifdef AES_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
`ifdef AES_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (aes_ct_valid_i) begin
                    ct_d    = aes_ct_i;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StResp;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
`endif
            end
            StResp: begin
                resp_valid_o = owner_oh;
                if (|(resp_ready_i & owner_oh)) begin
                    state_d = StIdle;
                    ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            pc_q    <= '0;
            st_q    <= '0;
            ksel_q  <= '0;
            ct_q    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pc_q    <= pc_d;
            st_q    <= st_d;
            ksel_q  <= ksel_d;
            ct_q    <= ct_d;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign resp_ct_o     = (state_q == StResp) ? ct_q : '0;
`ifdef AES_ARB_TIMEOUT_EN
    assign resp_err_o    = (state_q == StResp) && err_q;
`else
    assign resp_err_o    = 1'b0;
`endif
    assign aes_pc_o      = pc_q;
    assign aes_state_o   = st_q;
    assign aes_key_sel_o = ksel_q;
    assign busy_o        = (state_q != StIdle);
    assign grant_id_o    = grant_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter with a round-robin reference model.
// Build with AES_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_aes_job_arbiter;
    localparam int N  = 2;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     acct_en, req_valid, req_ready, resp_valid, resp_ready;
    logic             debug_mode;
    logic [N*128-1:0] req_pc, req_state;
    logic [N*2-1:0]   req_key_sel;
    logic [127:0]     resp_ct, aes_pc, aes_state, aes_ct;
    logic             resp_err, aes_start, aes_ct_valid, busy;
    logic [1:0]       aes_key_sel;
    logic [$clog2(N)-1:0] grant_id;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    logic [127:0] pc_arr [N];
    logic [127:0] st_arr [N];
    logic [1:0]   ks_arr [N];

    aes_job_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .acct_en_i(acct_en),
        .debug_mode_i(debug_mode),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_pc_i(req_pc),
        .req_state_i(req_state),
        .req_key_sel_i(req_key_sel),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_ct_o(resp_ct),
        .resp_err_o(resp_err),
        .aes_start_o(aes_start),
        .aes_pc_o(aes_pc),
        .aes_state_o(aes_state),
        .aes_key_sel_o(aes_key_sel),
        .aes_ct_i(aes_ct),
        .aes_ct_valid_i(aes_ct_valid),
        .busy_o(busy),
        .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    // Reference: first eligible requester scanning upward from ptr_m, wrapping.
    function automatic int model_grant();
        logic [N-1:0] e;
        e = debug_mode ? '0 : (req_valid & acct_en);
        for (int k = 0; k < N; k++) begin
            if (e[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_pc[i*128 +: 128]  = pc_arr[i];
            req_state[i*128 +: 128] = st_arr[i];
            req_key_sel[i*2 +: 2] = ks_arr[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            pc_arr[i] = rand128();
            st_arr[i] = rand128();
            ks_arr[i] = 2'($urandom_range(0, 3));
        end
        pack();
    endtask

    // Runs one job from an IDLE cycle; valid is raised in WAIT cycle number `delay`.
    task automatic run_job(input int delay, input bit stale, output int g);
        logic [127:0] exp_pc, exp_st, exp_ct;
        logic [1:0]   exp_ks;
        #1;
        g = model_grant();
        if (g < 0) begin
            chk("model_has_request", 128'(req_valid & acct_en), 128'(1));
            return;
        end
        chk("req_ready_onehot", 128'(req_ready), 128'(oh(g)));
        chk("idle_busy", 128'(busy), 128'(0));
        exp_pc = pc_arr[g];
        exp_st = st_arr[g];
        exp_ks = ks_arr[g];
        exp_ct = rand128();
        tick();
        if (stale) begin
            aes_ct_valid = 1'b1;
            aes_ct       = rand128();
        end
        #1;
        chk("issue_start", 128'(aes_start), 128'(1));
        chk("issue_grant_id", 128'(grant_id), 128'(g));
        chk("issue_pc", aes_pc, exp_pc);
        chk("issue_state", aes_state, exp_st);
        chk("issue_key_sel", 128'(aes_key_sel), 128'(exp_ks));
        chk("issue_req_ready", 128'(req_ready), 128'(0));
        tick();
        #1;
        chk("settle_start", 128'(aes_start), 128'(0));
        tick();
        aes_ct_valid = 1'b0;
        rand_ops();
        repeat (delay) tick();
        aes_ct_valid = 1'b1;
        aes_ct       = exp_ct;
        #1;
        chk("wait_no_resp", 128'(resp_valid), 128'(0));
        tick();
        aes_ct_valid = 1'b0;
        aes_ct       = rand128();
        #1;
        chk("resp_valid", 128'(resp_valid), 128'(oh(g)));
        chk("resp_ct", resp_ct, exp_ct);
        chk("resp_err", 128'(resp_err), 128'(0));
        chk("resp_pc_stable", aes_pc, exp_pc);
        resp_ready = ~oh(g);
        tick();
        #1;
        chk("resp_ignores_other_ready", 128'(resp_valid), 128'(oh(g)));
        chk("resp_ct_held", resp_ct, exp_ct);
        resp_ready = oh(g);
        tick();
        resp_ready = '0;
        #1;
        chk("post_resp_busy", 128'(busy), 128'(0));
        chk("post_resp_valid", 128'(resp_valid), 128'(0));
        chk("post_resp_ct_zero", resp_ct, 128'(0));
        ptr_m = (g + 1) % N;
    endtask

    initial begin
        int g;
        int n;
        logic [N-1:0] v, a;
        rst          = 1'b1;
        acct_en      = '0;
        req_valid    = '0;
        resp_ready   = '0;
        debug_mode   = 1'b0;
        aes_ct       = '0;
        aes_ct_valid = 1'b0;
        rand_ops();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_start", 128'(aes_start), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(resp_err), 128'(0));
        chk("rst_grant_id", 128'(grant_id), 128'(0));
        chk("rst_aes_pc", aes_pc, 128'(0));
        chk("rst_aes_state", aes_state, 128'(0));
        chk("rst_resp_ct", resp_ct, 128'(0));

        // Contention: both requesting continuously.
        acct_en   = '1;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            run_job(int'($urandom_range(0, 6)), 1'b0, g);
            chk("contention_order", 128'(g), 128'(k % 2));
        end

        // Single job from requester 0.
        req_valid = 2'b01;
        pc_arr[0] = 128'h00112233445566778899AABBCCDDEEFF;
        ks_arr[0] = 2'd1;
        pack();
        run_job(10, 1'b0, g);
        chk("single_grant", 128'(g), 128'(0));

        // Account gating.
        req_valid = 2'b11;
        acct_en   = 2'b10;
        run_job(3, 1'b0, g);
        chk("acct_gate_grant", 128'(g), 128'(1));

        // Debug mode blocks grants.
        acct_en    = '1;
        debug_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            #1;
            chk("debug_no_ready", 128'(req_ready), 128'(0));
            chk("debug_idle", 128'(busy), 128'(0));
        end
        debug_mode = 1'b0;
        run_job(2, 1'b0, g);

        // Stale valid across ISSUE/SETTLE.
        run_job(5, 1'b1, g);

        // Randomized jobs.
        for (int k = 0; k < 12; k++) begin
            v = N'($urandom_range(1, 3));
            a = N'($urandom_range(1, 3));
            if ((v & a) == '0) a = v;
            req_valid = v;
            acct_en   = a;
            run_job(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), g);
        end

`ifdef AES_ARB_TIMEOUT_EN
        req_valid = 2'b01;
        acct_en   = '1;
        #1;
        g = model_grant();
        chk("to_ready", 128'(req_ready), 128'(oh(g)));
        tick();
        tick();
        tick();
        n = 0;
        while (resp_valid === '0 && n < 100) begin
            n++;
            tick();
        end
        #1;
        chk("to_wait_cycles", 128'(n), 128'(TO));
        chk("to_resp_valid", 128'(resp_valid), 128'(oh(g)));
        chk("to_err", 128'(resp_err), 128'(1));
        chk("to_ct", resp_ct, 128'(0));
        resp_ready = oh(g);
        tick();
        resp_ready = '0;
        ptr_m = (g + 1) % N;
        run_job(4, 1'b0, g);
`else
        req_valid = 2'b01;
        acct_en   = '1;
        run_job(40, 1'b0, g);
`endif

        // Reset during WAIT: pointer must return to 0.
        req_valid = 2'b01;
        run_job(1, 1'b0, g);
        req_valid = 2'b10;
        #1;
        g = model_grant();
        chk("rstwait_ready", 128'(req_ready), 128'(oh(g)));
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rstwait_busy", 128'(busy), 128'(0));
        chk("rstwait_resp_valid", 128'(resp_valid), 128'(0));
        chk("rstwait_start", 128'(aes_start), 128'(0));
        chk("rstwait_grant_id", 128'(grant_id), 128'(0));
        chk("rstwait_aes_pc", aes_pc, 128'(0));
        ptr_m     = 0;
        req_valid = 2'b11;
        run_job(2, 1'b0, g);
        chk("rstwait_ptr_zero", 128'(g), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
